// File: rtl/sipo_pkg.sv
// Shared definitions for the serial/parallel lane converters: bit-order
// encodings, default geometry and a constant-context clog2 helper.
package sipo_pkg;

   localparam logic ORDER_MSB = 1'b1;
   localparam logic ORDER_LSB = 1'b0;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_LANES = 1;
   localparam int BEATS         = DEFAULT_WIDTH / DEFAULT_LANES;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// WIDTH-bit valid/ready holding register; a load is only issued by the
// owner when the register is free, so data never moves while stalled.
module sipo_out_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] data
);

   always_ff @(posedge clk) begin
      if (reset) begin
         data      <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         data      <= load_data;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_to_parallel_mlane.sv
// Multi-lane deserialiser: shifts LANES bits per accepted beat into a
// WIDTH-bit word and hands completed words to a valid/ready output register.
module serial_to_parallel_mlane
   import sipo_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int LANES = 1,
   localparam int CW    = clog2(WIDTH / LANES) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LANES-1:0] serial_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             msb_first,
   input  logic             flush,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    beat_count
);

   localparam int WORD_BEATS = WIDTH / LANES;

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] shift_msb;
   logic [WIDTH-1:0] shift_lsb;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] load_data;
   logic [CW-1:0]    count_inc;
   logic             order_q;
   logic             beat_order;
   logic             pending;
   logic             accept;
   logic             word_done;
   logic             out_free;
   logic             load;

   // A single-beat word has nothing to keep from the old contents.
   if (WIDTH == LANES) begin : g_single
      assign shift_msb = serial_in;
      assign shift_lsb = serial_in;
   end else begin : g_multi
      assign shift_msb = {sr[WIDTH-LANES-1:0], serial_in};
      assign shift_lsb = {serial_in, sr[WIDTH-1:LANES]};
   end

   assign in_ready = !pending;
   assign accept   = in_valid && in_ready;

   always_comb begin
      beat_order = (beat_count == '0) ? msb_first : order_q;
      shifted    = (beat_order == ORDER_MSB) ? shift_msb : shift_lsb;
      count_inc  = beat_count + CW'(1);
      word_done  = (count_inc == CW'(WORD_BEATS));
      out_free   = !out_valid || out_ready;
      load       = (pending && out_ready) || (accept && !flush && word_done && out_free);
      load_data  = pending ? sr : shifted;
   end

   // A pending word blocks input and ignores flush until the consumer drains the output.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr         <= '0;
         beat_count <= '0;
         order_q    <= ORDER_MSB;
         pending    <= 1'b0;
      end else if (pending) begin
         if (out_ready) begin
            pending    <= 1'b0;
            beat_count <= '0;
         end
      end else if (flush) begin
         sr         <= '0;
         beat_count <= '0;
      end else if (accept) begin
         sr <= shifted;
         if (beat_count == '0) begin
            order_q <= msb_first;
         end
         if (word_done && out_free) begin
            beat_count <= '0;
         end else begin
            beat_count <= count_inc;
            if (word_done) begin
               pending <= 1'b1;
            end
         end
      end
   end

   sipo_out_reg #(
      .WIDTH(WIDTH)
   ) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_data (load_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .data      (parallel_out)
   );

endmodule

// File: tb/tb_serial_to_parallel_mlane.sv
// Directed bench for the deserialiser: 8x1, 16x4 and 2x2 geometries with
// hand-computed words, backpressure, flush and reset cases.
module tb_serial_to_parallel_mlane;

   logic        clk;
   logic        reset;

   logic        serialA;
   logic        inValidA, inReadyA, msbFirstA, flushA, outValidA, outReadyA;
   logic [7:0]  parallelA;
   logic [3:0]  beatCountA;

   logic [3:0]  serialB;
   logic        inValidB, inReadyB, msbFirstB, flushB, outValidB, outReadyB;
   logic [15:0] parallelB;
   logic [2:0]  beatCountB;

   logic [1:0]  serialC;
   logic        inValidC, inReadyC, msbFirstC, flushC, outValidC, outReadyC;
   logic [1:0]  parallelC;
   logic        beatCountC;

   int checkCount;
   int passCount;

   serial_to_parallel_mlane #(.WIDTH(8), .LANES(1)) dutA (
      .clk(clk), .reset(reset), .serial_in(serialA), .in_valid(inValidA),
      .in_ready(inReadyA), .msb_first(msbFirstA), .flush(flushA),
      .parallel_out(parallelA), .out_valid(outValidA), .out_ready(outReadyA),
      .beat_count(beatCountA));

   serial_to_parallel_mlane #(.WIDTH(16), .LANES(4)) dutB (
      .clk(clk), .reset(reset), .serial_in(serialB), .in_valid(inValidB),
      .in_ready(inReadyB), .msb_first(msbFirstB), .flush(flushB),
      .parallel_out(parallelB), .out_valid(outValidB), .out_ready(outReadyB),
      .beat_count(beatCountB));

   serial_to_parallel_mlane #(.WIDTH(2), .LANES(2)) dutC (
      .clk(clk), .reset(reset), .serial_in(serialC), .in_valid(inValidC),
      .in_ready(inReadyC), .msb_first(msbFirstC), .flush(flushC),
      .parallel_out(parallelC), .out_valid(outValidC), .out_ready(outReadyC),
      .beat_count(beatCountC));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount = checkCount + 1;
      if (observed === expected) begin
         passCount = passCount + 1;
      end else begin
         $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", tag, observed, expected);
      end
   endtask

   // Sends bits[7] first on lane A; optionally flips msb_first after beat 3.
   task automatic applyStimulus(input logic [7:0] bits, input logic order, input bit toggleMid);
      msbFirstA = order;
      for (int i = 7; i >= 0; i--) begin
         inValidA = 1'b1;
         serialA  = bits[i];
         if (toggleMid && i == 4) msbFirstA = ~order;
         tick();
      end
      inValidA  = 1'b0;
      msbFirstA = order;
   endtask

   task automatic sendNibbles(input logic [15:0] nibbles, input logic order);
      msbFirstB = order;
      for (int i = 3; i >= 0; i--) begin
         inValidB = 1'b1;
         serialB  = nibbles[i*4 +: 4];
         tick();
      end
      inValidB = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset = 1'b1;
      serialA = 1'b0; inValidA = 1'b0; msbFirstA = 1'b1; flushA = 1'b0; outReadyA = 1'b1;
      serialB = 4'h0; inValidB = 1'b0; msbFirstB = 1'b1; flushB = 1'b0; outReadyB = 1'b1;
      serialC = 2'b0; inValidC = 1'b0; msbFirstC = 1'b1; flushC = 1'b0; outReadyC = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      checkOutput("rst_valid", {31'b0, outValidA}, 32'd0);
      checkOutput("rst_count", {28'b0, beatCountA}, 32'd0);
      checkOutput("rst_ready", {31'b0, inReadyA}, 32'd1);
      checkOutput("rst_data", {24'b0, parallelA}, 32'd0);

      // 8x1 MSB-first
      applyStimulus(8'hD5, 1'b1, 1'b0);
      checkOutput("msb_valid", {31'b0, outValidA}, 32'd1);
      checkOutput("msb_data", {24'b0, parallelA}, 32'hD5);
      checkOutput("msb_count", {28'b0, beatCountA}, 32'd0);
      tick();
      checkOutput("msb_valid_drop", {31'b0, outValidA}, 32'd0);

      // 8x1 LSB-first, order flipped mid-word
      applyStimulus(8'hD5, 1'b0, 1'b1);
      checkOutput("lsb_data", {24'b0, parallelA}, 32'hAB);
      checkOutput("lsb_valid", {31'b0, outValidA}, 32'd1);
      tick();

      // 16x4
      sendNibbles(16'hA53C, 1'b1);
      checkOutput("b_msb_data", {16'b0, parallelB}, 32'hA53C);
      checkOutput("b_msb_valid", {31'b0, outValidB}, 32'd1);
      sendNibbles(16'hA53C, 1'b0);
      checkOutput("b_lsb_data", {16'b0, parallelB}, 32'hC35A);
      checkOutput("b_count", {29'b0, beatCountB}, 32'd0);

      // Backpressure
      outReadyA = 1'b0;
      applyStimulus(8'h3C, 1'b1, 1'b0);
      checkOutput("bp_first", {24'b0, parallelA}, 32'h3C);
      applyStimulus(8'h81, 1'b1, 1'b0);
      checkOutput("bp_in_ready", {31'b0, inReadyA}, 32'd0);
      checkOutput("bp_hold", {24'b0, parallelA}, 32'h3C);
      checkOutput("bp_count", {28'b0, beatCountA}, 32'd8);
      tick();
      tick();
      checkOutput("bp_still_hold", {24'b0, parallelA}, 32'h3C);
      checkOutput("bp_still_valid", {31'b0, outValidA}, 32'd1);
      outReadyA = 1'b1;
      tick();
      checkOutput("bp_second", {24'b0, parallelA}, 32'h81);
      checkOutput("bp_second_valid", {31'b0, outValidA}, 32'd1);
      checkOutput("bp_ready_back", {31'b0, inReadyA}, 32'd1);
      checkOutput("bp_count_clr", {28'b0, beatCountA}, 32'd0);
      tick();
      checkOutput("bp_drain", {31'b0, outValidA}, 32'd0);

      // Flush
      msbFirstA = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inValidA = 1'b1; serialA = 1'b1; tick();
      end
      checkOutput("fl_count3", {28'b0, beatCountA}, 32'd3);
      flushA = 1'b1; inValidA = 1'b1; serialA = 1'b1;
      tick();
      flushA = 1'b0; inValidA = 1'b0;
      checkOutput("fl_count0", {28'b0, beatCountA}, 32'd0);
      checkOutput("fl_no_out", {31'b0, outValidA}, 32'd0);
      applyStimulus(8'hF0, 1'b1, 1'b0);
      checkOutput("fl_fresh", {24'b0, parallelA}, 32'hF0);
      tick();

      // Single-beat words
      inValidC = 1'b1; serialC = 2'b10; tick();
      checkOutput("c_data1", {30'b0, parallelC}, 32'h2);
      checkOutput("c_count1", {31'b0, beatCountC}, 32'd0);
      serialC = 2'b01; tick();
      inValidC = 1'b0;
      checkOutput("c_data2", {30'b0, parallelC}, 32'h1);
      checkOutput("c_valid2", {31'b0, outValidC}, 32'd1);

      // Reset mid-word
      for (int i = 0; i < 5; i++) begin
         inValidA = 1'b1; serialA = 1'b1; tick();
      end
      inValidA = 1'b0;
      checkOutput("rm_count5", {28'b0, beatCountA}, 32'd5);
      reset = 1'b1; tick(); reset = 1'b0;
      checkOutput("rm_count", {28'b0, beatCountA}, 32'd0);
      checkOutput("rm_valid", {31'b0, outValidA}, 32'd0);
      checkOutput("rm_data", {24'b0, parallelA}, 32'd0);

      // Reset with a pending word
      outReadyA = 1'b0;
      applyStimulus(8'h55, 1'b1, 1'b0);
      applyStimulus(8'h66, 1'b1, 1'b0);
      checkOutput("rp_pending", {31'b0, inReadyA}, 32'd0);
      reset = 1'b1; tick(); reset = 1'b0;
      checkOutput("rp_ready", {31'b0, inReadyA}, 32'd1);
      checkOutput("rp_valid", {31'b0, outValidA}, 32'd0);
      checkOutput("rp_count", {28'b0, beatCountA}, 32'd0);
      checkOutput("rp_data", {24'b0, parallelA}, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
